// File: rtl/count_display_mux_if.sv
// Display-mux bus: the counter value and capture strobe going in, and the
// segment/anode drive coming out. Master is the upstream side; slave is the mux.
interface count_display_mux_if;
  logic [3:0] count_in;
  logic       load;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output count_in,
    output load,
    input  seg,
    input  an
  );

  modport slave (
    input  count_in,
    input  load,
    output seg,
    output an
  );
endinterface

// File: rtl/count_display_mux.sv
// Four-digit multiplexed seven-segment driver fed by a 4-bit counter.
// Each load strobe shifts count_in into a 4-deep digit history; a free-running
// scan cycles DRIVE/BLANK slots across the digits.
// Optional build macro: LEAD_ZERO_BLANK_EN -- when defined, digits that have
// not yet been loaded since reset are kept dark during their DRIVE phase.
module count_display_mux #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  count_display_mux_if.slave bus
);

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  localparam logic [15:0] DRIVE_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [15:0] r_div;
  logic [3:0] r_hist [4];
  logic [6:0] r_seg;
  logic [3:0] r_an;

  logic [3:0] w_digit;
  logic [6:0] w_hex;
  logic       w_slot_en;

  // Digit history shift register; d0 takes the new value, older ones move up.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hist
    always_ff @(posedge clk) begin
      if (rst) begin
        r_hist[gi] <= 4'h0;
      end else if (bus.load) begin
        if (gi == 0) begin
          r_hist[gi] <= bus.count_in;
        end else begin
          r_hist[gi] <= r_hist[gi-1];
        end
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [2:0] r_fill;

  // Count loads since reset, saturating once all four digits hold real data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= 3'd0;
    end else if (bus.load && (r_fill != 3'd4)) begin
      r_fill <= r_fill + 3'd1;
    end
  end

  assign w_slot_en = ({1'b0, r_idx} < r_fill);
`else
  assign w_slot_en = 1'b1;
`endif

  assign w_digit = r_hist[r_idx];

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    w_hex = 7'h7F;
    case (w_digit)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  // Scan FSM with registered drive outputs one cycle behind the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_DRIVE;
      r_idx   <= 2'd0;
      r_div   <= 16'd0;
      r_an    <= 4'b1111;
      r_seg   <= 7'h7F;
    end else begin
      if ((r_state == S_DRIVE) && w_slot_en) begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_hex;
      end else begin
        r_an  <= 4'b1111;
        r_seg <= 7'h7F;
      end

      case (r_state)
        S_DRIVE: begin
          if (r_div == DRIVE_LAST) begin
            r_div   <= 16'd0;
            r_state <= S_BLANK;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_BLANK: begin
          if (r_div == BLANK_LAST) begin
            r_div   <= 16'd0;
            r_idx   <= r_idx + 2'd1;
            r_state <= S_DRIVE;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        default: begin
          r_div   <= 16'd0;
          r_state <= S_DRIVE;
        end
      endcase
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;

endmodule

// File: tb/tb_count_display_mux.sv
// Self-checking bench for count_display_mux with REFRESH_DIV=4, BLANK_CYC=2.
// The reference model derives the expected drive from elapsed cycles since
// reset and a list of loaded digits.
module tb_count_display_mux;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic clk;
  logic rst;

  count_display_mux_if bus();

  count_display_mux #(
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int         cyc;        // non-reset edges since reset release
  int         hist [4];   // hist[k] = digit k
  int         nloads;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  function automatic logic [6:0] hex7(input int v);
    logic [6:0] lut [16];
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return lut[v & 15];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
  task automatic step(input logic r, input logic ld, input logic [3:0] cin);
    int p, slot, off;
    bit lit;
    rst          = r;
    bus.load     = ld;
    bus.count_in = cin;
    @(posedge clk);
    if (r) begin
      cyc = 0;
      for (int k = 0; k < 4; k++) hist[k] = 0;
      nloads  = 0;
      exp_an  = 4'b1111;
      exp_seg = 7'h7F;
    end else begin
      cyc++;
      p    = (cyc - 1) % FRAME;
      slot = p / SLOT;
      off  = p % SLOT;
      lit  = (off < RD);
`ifdef LEAD_ZERO_BLANK_EN
      if (slot >= nloads) lit = 1'b0;
`endif
      if (lit) begin
        exp_an  = 4'b1111;
        exp_an[slot] = 1'b0;
        exp_seg = hex7(hist[slot]);
      end else begin
        exp_an  = 4'b1111;
        exp_seg = 7'h7F;
      end
      if (ld) begin
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(cin);
        if (nloads < 4) nloads++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'(i + 3));
      vectors++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'h7F) begin
        errors++;
        $display("FAIL reset: an=%b seg=%h required an=1111 seg=7f", bus.an, bus.seg);
      end
    end
    step(1'b0, 1'b0, 4'h0);
    vectors++;
`ifdef LEAD_ZERO_BLANK_EN
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7F) begin
`else
    if (bus.an !== 4'b1110 || bus.seg !== 7'h40) begin
`endif
      errors++;
      $display("FAIL reset_release: an=%b seg=%h required an=%b seg=%h",
               bus.an, bus.seg, exp_an, exp_seg);
    end
  endtask

  task automatic test_idle_scan();
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b0, 1'b0, 4'h0);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        $display("FAIL idle_scan cyc=%0d: an=%b seg=%h required an=%b seg=%h",
                 cyc, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_load_pattern();
    logic [3:0] vals [4];
    vals = '{4'h1, 4'h8, 4'hA, 4'hF};
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, vals[i]);
      step(1'b0, 1'b0, 4'h0);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 4'h0);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        $display("FAIL load_pattern cyc=%0d: an=%b seg=%h required an=%b seg=%h",
                 cyc, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_held_load();
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(i));
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 4'h0);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        $display("FAIL held_load cyc=%0d: an=%b seg=%h required an=%b seg=%h",
                 cyc, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_mid_slot_load();
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);          // DRIVE cycle 1 of slot 0
    step(1'b0, 1'b1, 4'h5);          // load during DRIVE cycle 2
    step(1'b0, 1'b0, 4'h0);
    vectors++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h12) begin
      errors++;
      $display("FAIL mid_slot_load: an=%b seg=%h required an=1110 seg=12", bus.an, bus.seg);
    end
    step(1'b0, 1'b0, 4'h0);          // DRIVE cycle 4
    vectors++;
    if (bus.an !== 4'b1110 || bus.seg !== exp_seg) begin
      errors++;
      $display("FAIL mid_slot_last: an=%b seg=%h required an=1110 seg=%h",
               bus.an, bus.seg, exp_seg);
    end
    step(1'b0, 1'b0, 4'h0);          // first BLANK cycle
    vectors++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7F) begin
      errors++;
      $display("FAIL mid_slot_end: an=%b seg=%h required an=1111 seg=7f", bus.an, bus.seg);
    end
  endtask

  task automatic test_reset_midslot();
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(9 + i));
    while (cyc < 2 * SLOT + 2) step(1'b0, 1'b0, 4'h0);   // inside slot 2 DRIVE
    step(1'b1, 1'b0, 4'h0);
    vectors++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset_midslot: an=%b seg=%h required an=1111 seg=7f", bus.an, bus.seg);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 4'h0);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        $display("FAIL reset_restart cyc=%0d: an=%b seg=%h required an=%b seg=%h",
                 cyc, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    int shown = 0;
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)));
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random i=%0d: an=%b seg=%h required an=%b seg=%h",
                   i, bus.an, bus.seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.count_in = 4'h0;
    cyc          = 0;
    nloads       = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    exp_an  = 4'b1111;
    exp_seg = 7'h7F;
    @(negedge clk);
    test_reset();
    test_idle_scan();
    test_load_pattern();
    test_held_load();
    test_mid_slot_load();
    test_reset_midslot();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/count_display_mux.md
COUNT_DISPLAY_MUX -- requirements
Module: count_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clk cycles each digit is driven per scan slot (legal range 2..65535).
REQ-002 Parameter BLANK_CYC, default 4, all-digits-off cycles between slots for anti-ghosting (legal range 1..255).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 count_in  input  4  value from the upstream 4-bit synchronous counter.
REQ-006 load  input  1  capture strobe; each high cycle pushes count_in into the digit history.
REQ-007 seg  output  7  registered segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 an  output  4  registered digit enables, active-low, one-hot-low when driving; an[0] = digit 0.

Function
REQ-009 History: four 4-bit registers d0..d3; on a non-reset cycle with load=1: d3<=d2, d2<=d1, d1<=d0, d0<=count_in.
REQ-010 load held high for N consecutive cycles shall perform N shifts; there shall be no edge detection.
REQ-011 Scan FSM states: DRIVE and BLANK; 2-bit slot index idx; divider counter div.
REQ-012 DRIVE: lasts exactly REFRESH_DIV cycles, then transitions to BLANK with div cleared.
REQ-013 BLANK: lasts exactly BLANK_CYC cycles, then idx<=idx+1 (mod 4, 3 wraps to 0) and transitions to DRIVE.
REQ-014 Slot period = REFRESH_DIV+BLANK_CYC cycles; frame period = 4x slot period.
REQ-015 Outputs are registered with 1-cycle latency from FSM state: in DRIVE, an = ~(1<<idx) and seg = hex(d[idx]); in BLANK, an=4'b1111 and seg=7'h7F.
REQ-016 Hex decode (active-low) is full 0-F: e.g. 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
REQ-017 A load during DRIVE of slot k updates the displayed value of slot k on the seg output 2 cycles after the load edge (shift, then output register), without restarting the slot timing.
REQ-018 The load path and the scan FSM shall be independent; no load pattern shall alter idx, div or state.

Reset
REQ-019 While rst=1: d0..d3=0, fill=0, idx=0, div=0, state=DRIVE, an=4'b1111, seg=7'h7F; load is ignored.
REQ-020 The first cycle after rst deasserts is DRIVE cycle 1 of slot 0; an=4'b1110 appears on the following cycle.
REQ-021 rst asserted mid-slot or mid-BLANK aborts immediately to the reset state; no partial slot completes.

Configuration
REQ-022 Macro LEAD_ZERO_BLANK_EN selects leading-digit blanking.
REQ-023 With LEAD_ZERO_BLANK_EN defined: a 3-bit fill counter increments on each load, saturating at 4; a slot with idx >= fill drives an=4'b1111 and seg=7'h7F for its DRIVE phase while keeping normal timing.
REQ-024 Without LEAD_ZERO_BLANK_EN: no fill counter; all four slots are always driven, and unloaded digits show 0 (7'h40).

Verification (REFRESH_DIV=4, BLANK_CYC=2, slot period 6, frame period 24)
REQ-025 Reset, then 24 idle cycles -> an sequence 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011..., 0111..., then wraps to 1110; seg=7'h40 in DRIVE (macro off).
REQ-026 load pulses with count_in=1,8,A,F -> d0=F, d1=A, d2=8, d3=1; slot seg values 7'h0E, 7'h08, 7'h00, 7'h79.
REQ-027 load held high for 5 cycles with count_in=0..4 -> d0=4, d1=3, d2=2, d3=1; the value 0 is shifted out.
REQ-028 Load of 5 on DRIVE cycle 2 of slot 0 -> seg=hex(5)=7'h12 two cycles later, and slot 0 still ends after 4 DRIVE cycles.
REQ-029 rst pulsed during slot 2 DRIVE -> next cycle an=1111, seg=7'h7F; the history is cleared; the scan restarts at slot 0.
REQ-030 LEAD_ZERO_BLANK_EN defined, one load of 7 -> only slot 0 enables (an=1110, seg=7'h78); slots 1-3 stay 1111; after 6 loads, all four slots are driven.
